pipe_scoreboard: RTL and testbench
==================================

Name: pipe_scoreboard

Overview:
- Parametrised register scoreboard for the in-order RISC-V pipeline. Generalises the non-forwarding hazard detector.
- Tracks each in-flight destination register with a per-register countdown. From that state it produces the ID-stage stall and, optionally, per-operand forwarding selects.
- Sits beside ID. Sees the instruction at the ID→EX boundary and is consulted by every source operand of the instruction in ID.

Parameters:
- NUM_REGS, 32, number of architectural registers; x0 is never tracked.
- AW, 5, register address width; must be ≥ clog2(NUM_REGS).
- NUM_RS, 2, number of source operands checked per instruction.
- DEPTH, 3, stages from EX through WB inclusive; legal range ≥ 3.
- CNT_W, clog2(DEPTH+1), counter width (derived, do not override).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_issue_vld  in  1  a valid instruction is in ID.
- i_issue_rd_wren  in  1  the ID instruction writes rd.
- i_issue_is_load  in  1  the ID instruction is a load.
- i_issue_rd  in  AW  destination register of the ID instruction.
- i_rs_addr  in  NUM_RS*AW  source addresses; operand k occupies bits [k*AW +: AW].
- i_rs_used  in  NUM_RS  per-operand "operand is actually read".
- i_flush  in  1  ID instruction is being squashed (branch taken in EX).
- o_stall  out  1  hold PC and the IF/ID register; insert a bubble into EX.
- o_fwd_sel  out  NUM_RS*2  per-operand source for EX: 0 = RF, 1 = MEM, 2 = WB; 3 is never driven.
- o_busy_vec  out  NUM_REGS  registered busy bit per register; bit 0 is always 0.
- o_stall_cnt  out  32  stall-cycle performance counter.

Behaviour:
- Entry state per register r (1..NUM_REGS-1): cnt[r] (CNT_W bits), ld[r] (1 bit). busy[r] = (cnt[r] != 0).
- Reset (i_rst_n = 0 at an edge): all cnt = 0, all ld = 0, o_stall_cnt = 0. Consequently o_stall = 0, o_fwd_sel = 0, o_busy_vec = 0.
- Reset takes effect mid-operation; all pending reservations are dropped.
- Issue fires = i_issue_vld & i_issue_rd_wren & (i_issue_rd != 0) & ~o_stall & ~i_flush.
- On issue: cnt[rd] <= DEPTH and ld[rd] <= i_issue_is_load. If rd is already busy, the younger instruction overwrites the entry.
- Every other entry with cnt != 0 decrements by 1 per cycle and saturates at 0.
- A per-cycle decrement never applies to the entry being issued that cycle.
- Operand k hazard lookup (combinational, uses pre-edge state): hit_k = i_rs_used[k] & (rs_k != 0) & busy[rs_k].
- Stall-only mode:
  - o_stall = i_issue_vld & OR over k of hit_k.
  - o_fwd_sel = 0.
  - A consumer is released in the cycle after the producer's WB edge, when cnt reaches 0.
- Forwarding-mode select per operand:
  - cnt == DEPTH and ld: stall.
  - cnt == DEPTH and not ld: sel = MEM.
  - cnt == DEPTH-1: sel = WB.
  - 1 ≤ cnt ≤ DEPTH-2: stall. The register file has no write-through, so cnt == 1 with DEPTH = 3 stalls one cycle.
  - No hit: sel = RF.
- While o_stall = 1, o_fwd_sel is don't-care; the bench checks it only when o_stall = 0.
- i_flush has priority over stall. The issue is suppressed and the scoreboard state still decrements.
- The instruction in ID never hazards against itself: lookup uses state before its own issue.
- o_stall_cnt increments when o_stall & ~i_flush, and saturates at 0xFFFF_FFFF.
- Latency: o_stall and o_fwd_sel are combinational from inputs and state in the same cycle. o_busy_vec reflects state after the last edge.

Optional Feature:
- PIPE_SCOREBOARD_FWD_EN defined: forwarding-mode selects and stall rules as above.
- Not defined: stall-only mode, o_fwd_sel tied to 0, ld state and the forwarding compare logic removed.
- Port list is identical in both builds.

Decomposition:
- Package sb_pkg holds:
  - fwd_sel_e enum: FWD_RF = 2'd0, FWD_MEM = 2'd1, FWD_WB = 2'd2.
  - Default AW/DEPTH localparams.
  - Function sb_cnt_w(depth) returning CNT_W.
- Sub-module sb_entry: one register's cnt/ld flops with issue-load and decrement. Generated NUM_REGS-1 times; the top keeps lookup, stall OR and the perf counter.

Test Plan:
- Reset with i_rst_n = 0 for 2 cycles, issue attempts ignored -> o_busy_vec = 0, o_stall = 0, o_stall_cnt = 0.
- Stall-only: `addi x5` issued, then `add x6,x5,x1` held in ID -> o_stall = 1 for exactly 3 cycles, released when cnt[5] = 0; o_stall_cnt = 3.
- FWD_EN: ALU writes x7, next instruction reads x7 -> no stall, o_fwd_sel = MEM. One-instruction gap -> WB. Two-instruction gap -> 1-cycle stall, then RF.
- FWD_EN: `lw x8` followed immediately by a reader of x8 -> 1-cycle stall, then o_fwd_sel = WB.
- Write to x0, or i_rs_used = 0 on a busy register -> o_stall = 0, and x0 is never reserved.
- i_flush = 1 on `addi x9` in ID -> busy[9] stays 0.
- Back-to-back writes to x10 -> cnt[10] reloads to 3 on the second issue, and busy lasts 3 cycles from the second issue.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared types and defaults for the pipeline register scoreboard.
// Forwarding logic elsewhere is enabled by defining PIPE_SCOREBOARD_FWD_EN.
package sb_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  localparam int unsigned SB_DEF_NUM_REGS = 32;
  localparam int unsigned SB_DEF_AW       = 5;
  localparam int unsigned SB_DEF_NUM_RS   = 2;
  localparam int unsigned SB_DEF_DEPTH    = 3;

  // Counter must hold DEPTH itself, so the width covers DEPTH+1 values.
  function automatic int unsigned sb_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_scoreboard_if.sv
// ID-stage <-> scoreboard signal bundle. The master side is the ID stage,
// the slave side is the scoreboard. Identical in both PIPE_SCOREBOARD_FWD_EN builds.
interface pipe_scoreboard_if #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NUM_RS   = 2
);

  logic                   i_issue_vld;
  logic                   i_issue_rd_wren;
  logic                   i_issue_is_load;
  logic [AW-1:0]          i_issue_rd;
  logic [NUM_RS*AW-1:0]   i_rs_addr;
  logic [NUM_RS-1:0]      i_rs_used;
  logic                   i_flush;

  logic                   o_stall;
  logic [NUM_RS*2-1:0]    o_fwd_sel;
  logic [NUM_REGS-1:0]    o_busy_vec;
  logic [31:0]            o_stall_cnt;

  modport master (
    output i_issue_vld, i_issue_rd_wren, i_issue_is_load, i_issue_rd,
           i_rs_addr, i_rs_used, i_flush,
    input  o_stall, o_fwd_sel, o_busy_vec, o_stall_cnt
  );

  modport slave (
    input  i_issue_vld, i_issue_rd_wren, i_issue_is_load, i_issue_rd,
           i_rs_addr, i_rs_used, i_flush,
    output o_stall, o_fwd_sel, o_busy_vec, o_stall_cnt
  );

endinterface

// File: rtl/sb_entry.sv
// One scoreboard entry: countdown of stages until the producer retires.
// With PIPE_SCOREBOARD_FWD_EN it also remembers whether the producer is a load.
module sb_entry
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEF_DEPTH,
  parameter int unsigned CNT_W = sb_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  output logic [CNT_W-1:0] cnt
`ifdef PIPE_SCOREBOARD_FWD_EN
  ,
  input  logic             is_load,
  output logic             ld
`endif
);

  // NOTE: reset is sampled on the clock edge (synchronous), so it sits inside
  // the edge-triggered block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every entry samples
    // pre-edge values regardless of evaluation order.
    if (!rst_n) begin
      cnt <= '0;
    end else if (issue) begin
      cnt <= CNT_W'(DEPTH);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

`ifdef PIPE_SCOREBOARD_FWD_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld <= 1'b0;
    end else if (issue) begin
      ld <= is_load;
    end
  end
`endif

endmodule

// File: rtl/pipe_scoreboard.sv
// In-order pipeline register scoreboard: ID-stage stall and optional operand
// forwarding selects. Define PIPE_SCOREBOARD_FWD_EN to enable forwarding mode.
module pipe_scoreboard
  import sb_pkg::*;
#(
  parameter int unsigned NUM_REGS = SB_DEF_NUM_REGS,
  parameter int unsigned AW       = SB_DEF_AW,
  parameter int unsigned NUM_RS   = SB_DEF_NUM_RS,
  parameter int unsigned DEPTH    = SB_DEF_DEPTH
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  pipe_scoreboard_if.slave   sb
);

  localparam int unsigned CNT_W = sb_cnt_w(DEPTH);

  logic [CNT_W-1:0]      cnt    [1:NUM_REGS-1];
  logic [NUM_REGS-1:0]   busy;
  logic [CNT_W-1:0]      rs_cnt [NUM_RS];
  logic [NUM_RS-1:0]     hit;
  logic [NUM_RS-1:0]     op_stall;
  logic [NUM_RS*2-1:0]   fwd_sel;
  logic                  stall;
  logic                  issue;
  logic [31:0]           stall_cnt;

`ifdef PIPE_SCOREBOARD_FWD_EN
  localparam logic [CNT_W-1:0] CNT_MEM = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_WB  = CNT_W'(DEPTH - 1);

  logic [NUM_REGS-1:1]   ld;
  logic [NUM_RS-1:0]     rs_ld;
`else
  logic unused_is_load;
  assign unused_is_load = sb.i_issue_is_load;
`endif

  // Flush and our own stall both squash the reservation; x0 is never reserved.
  assign issue = sb.i_issue_vld && sb.i_issue_rd_wren && (sb.i_issue_rd != '0)
              && !stall && !sb.i_flush;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    sb_entry #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
    ) u_entry (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .issue   (issue && (sb.i_issue_rd == AW'(r))),
      .cnt     (cnt[r])
`ifdef PIPE_SCOREBOARD_FWD_EN
      ,
      .is_load (sb.i_issue_is_load),
      .ld      (ld[r])
`endif
    );
  end

  always_comb begin
    busy[0] = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      busy[r] = (cnt[r] != '0);
    end
  end

  // Lookup sees pre-edge state only, so an instruction never hazards on itself.
  always_comb begin
    for (int k = 0; k < NUM_RS; k++) begin
      // NOTE: every combinational output gets a default before the loop body
      // so no path leaves it unassigned and no latch is inferred.
      rs_cnt[k] = '0;
`ifdef PIPE_SCOREBOARD_FWD_EN
      rs_ld[k]  = 1'b0;
`endif
      for (int r = 1; r < NUM_REGS; r++) begin
        if (sb.i_rs_addr[k*AW +: AW] == AW'(r)) begin
          rs_cnt[k] = cnt[r];
`ifdef PIPE_SCOREBOARD_FWD_EN
          rs_ld[k]  = ld[r];
`endif
        end
      end
      hit[k] = sb.i_rs_used[k] && (rs_cnt[k] != '0);
    end
  end

  always_comb begin
    fwd_sel  = '0;
    op_stall = '0;
    for (int k = 0; k < NUM_RS; k++) begin
`ifdef PIPE_SCOREBOARD_FWD_EN
      if (hit[k]) begin
        if (rs_cnt[k] == CNT_MEM) begin
          // A load's data is not available until it reaches WB.
          if (rs_ld[k]) op_stall[k] = 1'b1;
          else          fwd_sel[k*2 +: 2] = FWD_MEM;
        end else if (rs_cnt[k] == CNT_WB) begin
          fwd_sel[k*2 +: 2] = FWD_WB;
        end else begin
          // Register file has no write-through: wait until the entry clears.
          op_stall[k] = 1'b1;
        end
      end
`else
      op_stall[k] = hit[k];
`endif
    end
  end

  assign stall = sb.i_issue_vld && (|op_stall);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_cnt <= '0;
    end else if (stall && !sb.i_flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign sb.o_stall     = stall;
  assign sb.o_fwd_sel   = fwd_sel;
  assign sb.o_busy_vec  = busy;
  assign sb.o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed self-checking bench for pipe_scoreboard; expectations follow the
// build selected by PIPE_SCOREBOARD_FWD_EN.
module tb_pipe_scoreboard;

  logic i_clk = 1'b0;
  logic i_rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 i_clk = ~i_clk;

  pipe_scoreboard_if #(.NUM_REGS(32), .AW(5), .NUM_RS(2)) sb ();

  pipe_scoreboard #(
    .NUM_REGS (32),
    .AW       (5),
    .NUM_RS   (2),
    .DEPTH    (3)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .sb      (sb)
  );

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic vld, input logic wren, input logic is_load,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [1:0] used,
                       input logic flush);
    sb.i_issue_vld     = vld;
    sb.i_issue_rd_wren = wren;
    sb.i_issue_is_load = is_load;
    sb.i_issue_rd      = rd;
    sb.i_rs_addr       = {rs2, rs1};
    sb.i_rs_used       = used;
    sb.i_flush         = flush;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset for two edges while an issue of x5 is offered.
    i_rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0);
    step();
    step();
    check("rst_busy", sb.o_busy_vec, 32'h0);
    check("rst_stall_cnt", sb.o_stall_cnt, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 5'd6, 5'd5, 5'd0, 2'b01, 1'b0);
    check("rst_stall", sb.o_stall, 1'b0);
    check("rst_fwd", sb.o_fwd_sel, 4'h0);
    i_rst_n = 1'b1;

    // addi x5 then add x6,x5,x1 held in ID.
    drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd1, 5'd0, 2'b01, 1'b0);
    check("a_prod_stall", sb.o_stall, 1'b0);
    step();
    check("a_busy_x5", sb.o_busy_vec, 32'h0000_0020);
    drive(1'b1, 1'b1, 1'b0, 5'd6, 5'd5, 5'd1, 2'b11, 1'b0);
`ifdef PIPE_SCOREBOARD_FWD_EN
    check("a_fwd_stall", sb.o_stall, 1'b0);
    check("a_fwd_sel_mem", sb.o_fwd_sel, 4'h1);
    step();
    check("a_fwd_busy", sb.o_busy_vec, 32'h0000_0060);
`else
    check("a_stall_c1", sb.o_stall, 1'b1);
    step();
    check("a_stall_c2", sb.o_stall, 1'b1);
    step();
    check("a_stall_c3", sb.o_stall, 1'b1);
    step();
    check("a_released", sb.o_stall, 1'b0);
    check("a_fwd_zero", sb.o_fwd_sel, 4'h0);
    check("a_stall_cnt", sb.o_stall_cnt, 32'd3);
    check("a_busy_clear", sb.o_busy_vec, 32'h0);
    step();
    check("a_busy_x6", sb.o_busy_vec, 32'h0000_0040);
`endif
    idle();
    repeat (4) step();
    check("a_drained", sb.o_busy_vec, 32'h0);

`ifdef PIPE_SCOREBOARD_FWD_EN
    // ALU producer x7 consumed at distance 1, 2 and 3.
    drive(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 2'b00, 1'b0);
    step();
    drive(1'b1, 1'b1, 1'b0, 5'd11, 5'd7, 5'd0, 2'b01, 1'b0);
    check("f_d1_stall", sb.o_stall, 1'b0);
    check("f_d1_mem_op0", sb.o_fwd_sel, 4'h1);
    drive(1'b1, 1'b1, 1'b0, 5'd11, 5'd0, 5'd7, 2'b10, 1'b0);
    check("f_d1_mem_op1", sb.o_fwd_sel, 4'h4);
    idle();
    step();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 2'b01, 1'b0);
    check("f_d2_stall", sb.o_stall, 1'b0);
    check("f_d2_wb", sb.o_fwd_sel, 4'h2);
    idle();
    step();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 2'b01, 1'b0);
    check("f_d3_stall", sb.o_stall, 1'b1);
    step();
    check("f_d3_release", sb.o_stall, 1'b0);
    check("f_d3_rf", sb.o_fwd_sel, 4'h0);
    idle();
    step();

    // lw x8 immediately followed by a reader of x8.
    drive(1'b1, 1'b1, 1'b1, 5'd8, 5'd0, 5'd0, 2'b00, 1'b0);
    step();
    drive(1'b1, 1'b1, 1'b0, 5'd12, 5'd8, 5'd0, 2'b01, 1'b0);
    check("f_ld_stall", sb.o_stall, 1'b1);
    step();
    check("f_ld_release", sb.o_stall, 1'b0);
    check("f_ld_wb", sb.o_fwd_sel, 4'h2);
    step();
    check("f_ld_busy", sb.o_busy_vec, 32'h0000_1100);
    idle();
    repeat (4) step();
    check("f_drained", sb.o_busy_vec, 32'h0);
    check("f_stall_cnt", sb.o_stall_cnt, 32'd2);
`endif

    // x0 is never reserved and never hazards.
    drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'b11, 1'b0);
    check("x0_stall", sb.o_stall, 1'b0);
    step();
    check("x0_busy", sb.o_busy_vec, 32'h0);

    // Busy register not read (rs_used = 0) must not stall.
    drive(1'b1, 1'b1, 1'b0, 5'd13, 5'd0, 5'd0, 2'b00, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd13, 5'd13, 2'b00, 1'b0);
    check("unused_stall", sb.o_stall, 1'b0);
    check("unused_fwd", sb.o_fwd_sel, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd13, 5'd13, 2'b10, 1'b0);
`ifdef PIPE_SCOREBOARD_FWD_EN
    check("used_op1_stall", sb.o_stall, 1'b0);
    check("used_op1_mem", sb.o_fwd_sel, 4'h4);
`else
    check("used_op1_stall", sb.o_stall, 1'b1);
`endif
    idle();
    repeat (3) step();
    check("unused_drained", sb.o_busy_vec, 32'h0);

    // Flushed addi x9 reserves nothing.
    drive(1'b1, 1'b1, 1'b0, 5'd9, 5'd0, 5'd0, 2'b00, 1'b1);
    step();
    check("flush_busy9", sb.o_busy_vec, 32'h0);

    // Flush beats stall: no count, no issue, state keeps counting down.
    drive(1'b1, 1'b1, 1'b0, 5'd14, 5'd0, 5'd0, 2'b00, 1'b0);
    step();
    drive(1'b1, 1'b1, 1'b0, 5'd15, 5'd14, 5'd0, 2'b01, 1'b1);
`ifdef PIPE_SCOREBOARD_FWD_EN
    check("flush_stall_raw", sb.o_stall, 1'b0);
`else
    check("flush_stall_raw", sb.o_stall, 1'b1);
`endif
    step();
    check("flush_busy", sb.o_busy_vec, 32'h0000_4000);
`ifdef PIPE_SCOREBOARD_FWD_EN
    check("flush_stall_cnt", sb.o_stall_cnt, 32'd2);
`else
    check("flush_stall_cnt", sb.o_stall_cnt, 32'd3);
`endif
    idle();
    repeat (2) step();
    check("flush_decrement", sb.o_busy_vec, 32'h0);

    // Back-to-back writes to x10 reload the countdown.
    drive(1'b1, 1'b1, 1'b0, 5'd10, 5'd0, 5'd0, 2'b00, 1'b0);
    step();
    step();
    check("b2b_issue2", sb.o_busy_vec, 32'h0000_0400);
    idle();
    step();
    check("b2b_cnt2", sb.o_busy_vec, 32'h0000_0400);
    step();
    check("b2b_cnt1", sb.o_busy_vec, 32'h0000_0400);
    step();
    check("b2b_cnt0", sb.o_busy_vec, 32'h0);

    // Reset mid-operation drops the reservation and the counter.
    drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0);
    step();
    check("mid_busy", sb.o_busy_vec, 32'h0000_0020);
    idle();
    i_rst_n = 1'b0;
    step();
    check("mid_rst_busy", sb.o_busy_vec, 32'h0);
    check("mid_rst_cnt", sb.o_stall_cnt, 32'h0);
    i_rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 2'b01, 1'b0);
    check("mid_rst_stall", sb.o_stall, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
